// File: rtl/decoder_structural.sv
// 3-to-8 one-hot decoder with active-high enable. Gate-level decode feeds
// a bank of eight D flip-flops, so every output is a flop Q.
module decoder_structural (
  input  logic clk,
  input  logic rst,
  input  logic e,
  input  logic a,
  input  logic b,
  input  logic c,
  output logic d0,
  output logic d1,
  output logic d2,
  output logic d3,
  output logic d4,
  output logic d5,
  output logic d6,
  output logic d7
);

  logic       a_n;
  logic       b_n;
  logic       c_n;
  logic [1:0] a_lit;
  logic [1:0] b_lit;
  logic [1:0] c_lit;
  logic [7:0] d_next;
  logic [7:0] d_reg;

  not u_inv_a (a_n, a);
  not u_inv_b (b_n, b);
  not u_inv_c (c_n, c);

  // Index 0 holds the complemented literal, index 1 the true literal.
  assign a_lit = {a, a_n};
  assign b_lit = {b, b_n};
  assign c_lit = {c, c_n};

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi = gi + 1) begin : g_and
      localparam logic [2:0] K = 3'(gi);
      and u_and (d_next[gi], e, a_lit[K[2]], b_lit[K[1]], c_lit[K[0]]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      d_reg <= '0;
    end else begin
      d_reg <= d_next;
    end
  end

  assign d0 = d_reg[0];
  assign d1 = d_reg[1];
  assign d2 = d_reg[2];
  assign d3 = d_reg[3];
  assign d4 = d_reg[4];
  assign d5 = d_reg[5];
  assign d6 = d_reg[6];
  assign d7 = d_reg[7];

endmodule

// File: tb/tb_decoder_structural.sv
// Self-checking bench for decoder_structural: directed test-plan steps plus
// randomized cycles compared against a shift-based reference model.
module tb_decoder_structural;

  logic clk;
  logic rst;
  logic e;
  logic a;
  logic b;
  logic c;
  logic d0, d1, d2, d3, d4, d5, d6, d7;
  logic [7:0] d_obs;
  logic [7:0] exp_reg;
  int errors;
  int checks;

  decoder_structural dut (
    .clk(clk), .rst(rst), .e(e), .a(a), .b(b), .c(c),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .d4(d4), .d5(d5), .d6(d6), .d7(d7)
  );

  assign d_obs = {d7, d6, d5, d4, d3, d2, d1, d0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: reset clears; enabled decode sets bit number abc; else zero.
  function automatic logic [7:0] model(input logic r, input logic en, input logic [2:0] sel);
    if (r) return 8'h00;
    if (en) return 8'h01 << sel;
    return 8'h00;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Drive inputs, take one rising edge, then compare #1 later.
  task automatic step(input string tag, input logic r, input logic en, input logic [2:0] sel);
    rst = r; e = en; {a, b, c} = sel;
    exp_reg = model(r, en, sel);
    @(posedge clk);
    #1;
    $display("step %s rst=%0b e=%0b abc=%03b d=%08b exp=%08b", tag, r, en, sel, d_obs, exp_reg);
    check(tag, d_obs, exp_reg);
    checks++;
    assert ($countones(d_obs) <= 1) else begin
      errors++;
      $error("FAIL %s_onehot observed=%b expected=at_most_one_bit", tag, d_obs);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0; e = 1'b0; a = 1'b0; b = 1'b0; c = 1'b0;
    @(negedge clk);

    // Reset with all inputs high, then release.
    step("reset0", 1'b1, 1'b1, 3'b111);
    step("reset1", 1'b1, 1'b1, 3'b111);
    step("reset_release", 1'b0, 1'b1, 3'b111);

    for (int k = 0; k < 8; k++) step("en_low_sweep", 1'b0, 1'b0, 3'(k));
    for (int k = 0; k < 8; k++) step("en_high_sweep", 1'b0, 1'b1, 3'(k));

    step("toggle_1", 1'b0, 1'b1, 3'b010);
    step("toggle_0", 1'b0, 1'b0, 3'b010);
    step("toggle_1b", 1'b0, 1'b1, 3'b010);

    // Mid-cycle input change must not reach the outputs before the edge.
    step("latency_011", 1'b0, 1'b1, 3'b011);
    #2;
    {a, b, c} = 3'b100;
    #1;
    check("latency_hold_d3", d_obs, 8'b0000_1000);
    @(posedge clk);
    #1;
    check("latency_d4", d_obs, 8'b0001_0000);

    step("midrst_d6", 1'b0, 1'b1, 3'b110);
    step("midrst_clear", 1'b1, 1'b1, 3'b110);
    step("midrst_release", 1'b0, 1'b1, 3'b110);

    for (int i = 0; i < 200; i++) begin
      step("random", ($urandom_range(0, 19) == 0), 1'($urandom), 3'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decoder_structural.md
Name: decoder_structural

Overview:
3-to-8 line decoder with active-high enable, built from gate primitives and followed by an output register stage. The select inputs a (MSB), b and c (LSB) choose one of eight outputs d0..d7. When enable e is high, the chosen output is driven high. The block serves as a one-hot select generator for downstream address/chip-select logic.

Parameters:
None. All widths are fixed.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
e    input  1  decoder enable, active-high
a    input  1  select bit 2 (MSB)
b    input  1  select bit 1
c    input  1  select bit 0 (LSB)
d0   output 1  registered, high when e=1 and {a,b,c}=3'b000
d1   output 1  registered, high when e=1 and {a,b,c}=3'b001
d2   output 1  registered, high when e=1 and {a,b,c}=3'b010
d3   output 1  registered, high when e=1 and {a,b,c}=3'b011
d4   output 1  registered, high when e=1 and {a,b,c}=3'b100
d5   output 1  registered, high when e=1 and {a,b,c}=3'b101
d6   output 1  registered, high when e=1 and {a,b,c}=3'b110
d7   output 1  registered, high when e=1 and {a,b,c}=3'b111

Behaviour:
- Interface decision: one clock (clk); reset rst is synchronous and active-high.
- Decode stage is combinational and structural:
  - inverters produce a_n, b_n and c_n;
  - eight 4-input AND gates produce next_dk = e & (a or a_n) & (b or b_n) & (c or c_n), with literals matching the binary value of k.
- Register stage: eight D flip-flops, one per output. The outputs are flop Q values, with no combinational path from inputs to outputs.
- Reset: when rst=1 at a rising clk edge, d0..d7 all become 0 regardless of e, a, b and c. Reset has priority over decode. Before the first reset, output values are unspecified.
- Latency: exactly 1 clock cycle. Inputs sampled at edge N appear on d0..d7 after edge N and hold until edge N+1.
- Enable low: if e=0 at a sampling edge, all outputs become 0 for every value of a, b and c.
- Enable high: exactly one output is 1, namely d[{a,b,c}]. The other seven are 0.
- Invariant: at any time after reset, at most one of d0..d7 is 1 (one-hot or all-zero).
- Inputs changing between edges have no effect until the next rising edge. No input synchronisation is provided; inputs must be synchronous to clk.
- Reset mid-operation: the edge with rst=1 clears all outputs. The first edge after rst deasserts decodes normally, with no extra cycle.
- The block has no other state: no FSM and no counters.

Test Plan:
- Reset: hold e=1, a=1, b=1, c=1 and assert rst for 2 cycles -> d0..d7 all 0. Deassert rst -> after 1 edge d7=1 and all others 0.
- Enable low sweep: e=0 with {a,b,c} stepped through 000..111, one setting per cycle -> d0..d7 all 0 on every cycle.
- Enable high sweep: e=1 with {a,b,c} stepped through 000..111 -> one cycle later dk=1 for k=0..7 and all other outputs 0. Example: abc=101 gives d5=1.
- Enable toggle: abc=010 with e alternating 1,0,1 on successive cycles -> d2 goes 1,0,1 one cycle delayed, and all other outputs stay 0 throughout.
- Latency and glitch-free check: change abc from 011 to 100 mid-cycle with e=1 -> d3 stays 1 until the next edge, then d4=1 and d3=0. Neither output changes between edges.
- Mid-operation reset: e=1, abc=110 with d6=1, then assert rst for one edge -> all outputs 0. Release rst with inputs held -> d6=1 on the next edge.
